// File: rtl/dec38_scan_pkg.sv
// rtl/dec38_scan_pkg.sv - shared state enum, LED count and one-hot helper for dec38_scan
package dec38_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

  localparam int unsigned LED_N = 8;

  function automatic logic [LED_N-1:0] onehot(input logic [2:0] c);
    logic [LED_N-1:0] r;
    r    = '0;
    r[c] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/dec38_scan_tick_div.sv
// rtl/dec38_scan_tick_div.sv - tick_div: DIV_W-bit prescaler, counts 0..DIV_MAX, pulses tc_o at terminal count
module tick_div #(
  parameter int unsigned DIV_W   = 24,
  parameter int unsigned DIV_MAX = 12499999
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // tc_o does not depend on clr_i so a clear at terminal count still produces the pulse
  assign tc_o = en_i && (cnt_q == DIV_W'(DIV_MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tc_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dec38_scan.sv
// rtl/dec38_scan.sv - registered 3-to-8 one-hot LED decoder with latched code register
// Optional auto-scan walker (SCAN state, prescaler, tick) enabled by defining DEC38_SCAN_EN.
module dec38_scan #(
  parameter int unsigned DIV_W   = 24,
  parameter int unsigned DIV_MAX = 12499999
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [2:0] in_i,
  input  logic       load_i,
  input  logic       en_i,
  input  logic       mode_i,
  output logic [7:0] out_o,
  output logic [2:0] code_o,
  output logic       tick_o
);

  import dec38_scan_pkg::*;

  state_e           state_q, state_d;
  logic [LED_N-1:0] out_q, out_d;
  logic [2:0]       code_q, code_d;
  logic             tick_q, tick_d;
  logic             tc;

`ifdef DEC38_SCAN_EN
  tick_div #(
    .DIV_W  (DIV_W),
    .DIV_MAX(DIV_MAX)
  ) u_tick_div (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i ((state_d != SCAN) || load_i),
    .en_i  (state_d == SCAN),
    .tc_o  (tc)
  );
`else
  logic unused_mode;
  assign unused_mode = mode_i;
  assign tc          = 1'b0;
`endif

  // state_q is kept for debug visibility; all outputs follow the next state directly
  logic unused_state;
  assign unused_state = ^state_q;

  always_comb begin
    state_d = IDLE;
    if (en_i) begin
      state_d = HOLD;
`ifdef DEC38_SCAN_EN
      if (mode_i) begin
        state_d = SCAN;
      end
`endif
    end
  end

  always_comb begin
    code_d = code_q;
    if (load_i) begin
      code_d = in_i;
    end else if (tc) begin
      code_d = code_q + 3'd1;
    end
    tick_d = tc;
    out_d  = (state_d == IDLE) ? '0 : onehot(code_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      out_q   <= '0;
      code_q  <= 3'd0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      code_q  <= code_d;
      tick_q  <= tick_d;
    end
  end

  assign out_o  = out_q;
  assign code_o = code_q;
  assign tick_o = tick_q;

endmodule

// File: doc/dec38_scan.md
# dec38_scan

Registered 3-to-8 one-hot decoder with a latched code register and an optional auto-scan walker. It is the counterpart of the board's 8-to-3 switch priority encoder. It turns a 3-bit code into one lit LED out of eight and holds that code stably. In scan mode it steps the lit LED 0→7→0 at a prescaled rate for the lab board's LED bank.

## Interface
- DIV_W, 24, prescaler counter width
- DIV_MAX, 12499999, prescaler terminal count; scan step period = DIV_MAX+1 clk cycles; must be < 2^DIV_W
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- in  input  3  code to load
- load  input  1  single-cycle load strobe; samples `in`
- en  input  1  display enable; low blanks output
- mode  input  1  0 = hold, 1 = scan (ignored without DEC38_SCAN_EN)
- out  output  8  one-hot decoded LEDs, registered
- code  output  3  current code register
- tick  output  1  one-cycle pulse at each scan step

## Operation
- Every output is registered.
- Reset values: out=8'h00, code=3'd0, tick=0, state=IDLE, prescaler=0.
- States:
  - IDLE: en=0. out=0; code still loads on `load`; prescaler held at 0.
  - HOLD: en=1, mode=0. out = 1<<code; prescaler held at 0.
  - SCAN: en=1, mode=1. Prescaler counts 0..DIV_MAX. At terminal count it wraps to 0, code increments, and tick pulses.
- Transitions, evaluated each cycle from en/mode:
  - en=0 → IDLE, from any state.
  - en=1, mode=0 → HOLD.
  - en=1, mode=1 → SCAN.
- Code increment is mod 8: 3'd7 → 3'd0.
- load has priority over the scan increment. When load and the terminal count coincide:
  - code = in;
  - prescaler restarts at 0;
  - tick is still asserted.
- load during SCAN also restarts the prescaler. Scanning continues from the loaded code.
- SCAN→HOLD freezes code at its current value. HOLD→SCAN begins a full period from prescaler 0.
- out is always 8'h00 or exactly one bit set. It is never multi-hot.
- Without DEC38_SCAN_EN, `in` values outside 0..7 cannot occur (3-bit). No default branch produces a blank except in IDLE.

## Timing
- load at edge N → code and out reflect `in` after edge N+1 (1-cycle latency).
- en fall at edge N → out=0 after edge N+1. en rise → out = 1<<code after edge N+1.
- Scan step: tick is high for the cycle in which code/out show the new value. The first step comes DIV_MAX+1 cycles after entering SCAN.
- rst assertion clears all state immediately, with no clock needed. This holds mid-scan and mid-load. Deassertion is sampled synchronously; the first load is honoured on the first edge after release.

## Configuration
- DEC38_SCAN_EN defined:
  - SCAN state exists;
  - prescaler and tick logic are present;
  - mode is honoured.
- DEC38_SCAN_EN undefined:
  - mode is ignored, and en=1 always means HOLD;
  - the prescaler is removed;
  - tick is tied to 0;
  - code changes only on load.

## Structure
- The shared package holds the state enum (IDLE, HOLD, SCAN) and the LED count constant (8).
- One sub-module, `tick_div`: a parameterised DIV_W/DIV_MAX prescaler with clear and enable inputs and a terminal-count pulse output. It is instantiated only under DEC38_SCAN_EN.

## Test plan
All scenarios use DIV_MAX=3.
- Reset → out=8'h00, code=0, tick=0. Assert rst low mid-scan → all outputs 0 asynchronously.
- en=1, mode=0, load with in=3'd5 → next cycle code=5, out=8'b0010_0000. No further change over 20 cycles.
- en=1, mode=1, code=6 → after 4 cycles code=7, out=8'h80, tick=1 for one cycle. After 4 more cycles code=0, out=8'h01 (wrap).
- In SCAN, load in=3'd2 on the cycle of the terminal count → code=2 (not the incremented value), prescaler restarts, next step occurs 4 cycles later to code=3.
- en dropped while code=4 → out=8'h00 next cycle, code stays 4. Re-raise en → out=8'h10 next cycle.
- Build without DEC38_SCAN_EN, mode=1, en=1 → code stays constant, tick never asserts, load still works.
